conv_encoder_sys: RTL and testbench

- Rate-1/2, K=3 convolutional encoder that sits directly upstream of decoder_sys and produces the 2-bit symbol stream it consumes.
- Accepts a serial message bit stream with a valid/ready handshake.
- Frames every MSG_LEN data bits and appends K-1 zero tail bits so the trellis terminates in state 00.
- Emits one registered symbol per accepted bit, with backpressure.

---
 rtl/conv_encoder_sys.sv | 132 +++++++++++++
 tb/tb_conv_encoder_sys.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_sys.sv
// Rate-1/2, K=3 convolutional encoder with framing (MSG_LEN data bits + 2 zero tail bits),
// single-register output slot and valid/ready on both sides. Optional macro: CONV_ERR_INJECT_EN.
module conv_encoder_sys #(
  parameter int         MSG_LEN = 13,
  parameter logic [2:0] G0      = 3'b111,
  parameter logic [2:0] G1      = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] encoded_bits,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sof,
  output logic       eof,
  output logic       busy
`ifdef CONV_ERR_INJECT_EN
  ,
  input  logic [1:0] err_mask,
  output logic [7:0] err_count
`endif
);

  localparam int CW = $clog2(MSG_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t        state, state_nxt;
  logic          s1, s2;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [1:0]    tail_cnt, tail_cnt_nxt;
  logic          slot_free, gen, enc_in, sof_nxt, eof_nxt;
  logic [2:0]    taps;
  logic [1:0]    sym;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && (state != TAIL);
  assign busy      = (state != IDLE);

  // Tail symbols are produced whenever the slot frees up; data symbols need an input transfer.
  assign gen    = (state == TAIL) ? slot_free : (in_valid && in_ready);
  assign enc_in = (state == TAIL) ? 1'b0 : in_bit;
  assign taps   = {enc_in, s1, s2};

`ifdef CONV_ERR_INJECT_EN
  assign sym = {^(G0 & taps), ^(G1 & taps)} ^ err_mask;
`else
  assign sym = {^(G0 & taps), ^(G1 & taps)};
`endif

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    tail_cnt_nxt = tail_cnt;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    case (state)
      IDLE: if (gen) begin
        sof_nxt      = 1'b1;
        bit_cnt_nxt  = CW'(1);
        tail_cnt_nxt = 2'd0;
        state_nxt    = (MSG_LEN == 1) ? TAIL : DATA;
      end
      DATA: if (gen) begin
        bit_cnt_nxt = bit_cnt + CW'(1);
        if (bit_cnt_nxt == CW'(MSG_LEN)) begin
          tail_cnt_nxt = 2'd0;
          state_nxt    = TAIL;
        end
      end
      TAIL: if (gen) begin
        tail_cnt_nxt = tail_cnt + 2'd1;
        if (tail_cnt == 2'd1) begin
          eof_nxt     = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero tail bits flush s1/s2, so a new frame always starts from trellis state 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      bit_cnt      <= '0;
      tail_cnt     <= 2'd0;
      out_valid    <= 1'b0;
      encoded_bits <= 2'b00;
      sof          <= 1'b0;
      eof          <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tail_cnt <= tail_cnt_nxt;
      if (gen) begin
        s2 <= s1;
        s1 <= enc_in;
      end
      if (slot_free) begin
        out_valid <= gen;
        if (gen) begin
          encoded_bits <= sym;
          sof          <= sof_nxt;
          eof          <= eof_nxt;
        end else begin
          sof <= 1'b0;
          eof <= 1'b0;
        end
      end
    end
  end

`ifdef CONV_ERR_INJECT_EN
  logic [8:0] err_sum;
  assign err_sum = {1'b0, err_count} + 9'(err_mask[1]) + 9'(err_mask[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (gen) begin
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Self-checking bench for conv_encoder_sys: directed frames plus randomized traffic,
// compared against a convolution model computed from the generator polynomials.
module tb_conv_encoder_sys;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit, in_valid, in_ready;
  logic [1:0] encoded_bits;
  logic       out_valid, out_ready, sof, eof, busy;
  logic [1:0] err_mask = 2'b00;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  bit         in_q[$];
  bit         inject_next = 1'b0;

  always #5 clk = ~clk;

  conv_encoder_sys dut (
    .clk(clk),
    .rst(rst),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .encoded_bits(encoded_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sof(sof),
    .eof(eof),
    .busy(busy)
`ifdef CONV_ERR_INJECT_EN
    ,
    .err_mask(err_mask),
    .err_count(err_count)
`endif
  );

`ifndef CONV_ERR_INJECT_EN
  assign err_count = 8'd0;
`endif

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame symbols: out[1] = x[n]^x[n-1]^x[n-2], out[0] = x[n]^x[n-2], with two zero tail bits.
  task automatic add_frame(input logic [12:0] msg);
    bit x[15];
    bit b1, b2;
    for (int i = 0; i < 15; i++) x[i] = (i < 13) ? msg[i] : 1'b0;
    for (int i = 0; i < 15; i++) begin
      b1 = 1'b0;
      b2 = 1'b0;
      if (i >= 1) b1 = x[i-1];
      if (i >= 2) b2 = x[i-2];
      exp_q.push_back({x[i] ^ b1 ^ b2, x[i] ^ b2, i == 0, i == 14});
      if (i < 13) in_q.push_back(x[i]);
    end
  endtask

  // mode 0: out_ready high, 1: out_ready toggles, 2: random ready and valid
  task automatic applyStimulus(input int mode, input int max_cycles,
                               output int low_ready, output int gaps);
    logic       prev_stall = 1'b0;
    logic [3:0] prev_sym = 4'd0;
    logic [3:0] obs;
    bit         started = 1'b0;
    bit         done = 1'b0;
    low_ready = 0;
    gaps = 0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      obs = {encoded_bits, sof, eof};
      if (prev_stall) begin
        checkOutput("stall_valid", 8'(out_valid), 8'd1);
        checkOutput("stall_hold", 8'(obs), 8'(prev_sym));
      end
      if (in_q.size() == 0 && exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (cyc % 2 == 0);
      else out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (in_q.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
      in_bit = (in_q.size() > 0) ? in_q[0] : 1'b0;
      err_mask = 2'b00;
      #1;
      if (!in_ready) low_ready++;
      if (started && !out_valid && exp_q.size() > 0) gaps++;
      if (out_valid && out_ready) begin
        started = 1'b1;
        if (exp_q.size() == 0) checkOutput("extra_symbol", 8'(exp_q.size()), 8'd1);
        else checkOutput("symbol", 8'(obs), 8'(exp_q.pop_front()));
      end
      if (inject_next && in_valid && in_ready && exp_q.size() > 0) begin
        inject_next = 1'b0;
        err_mask = 2'b01;
        exp_q[0] = exp_q[0] ^ 4'b0100;
      end
      if (in_valid && in_ready) void'(in_q.pop_front());
      prev_stall = out_valid && !out_ready;
      prev_sym = obs;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("run_done", 8'(done), 8'd1);
    in_valid = 1'b0;
    err_mask = 2'b00;
  endtask

  initial begin
    int lr, gp;
    logic [12:0] m;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bit = 1'b0;
    out_ready = 1'b1;
    #12;
    checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
    checkOutput("rst_encoded", 8'(encoded_bits), 8'd0);
    checkOutput("rst_sof", 8'(sof), 8'd0);
    checkOutput("rst_eof", 8'(eof), 8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    checkOutput("rst_in_ready", 8'(in_ready), 8'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed frame 1,0,1,1,0...");
    add_frame(13'b0_0000_0000_1101);
    applyStimulus(0, 100, lr, gp);
    checkOutput("tail_ready_low", 8'(lr), 8'd2);
    checkOutput("no_gap", 8'(gp), 8'd0);
    checkOutput("idle_after", 8'(busy), 8'd0);

    $display("[TB] same frame with out_ready toggling");
    add_frame(13'b0_0000_0000_1101);
    applyStimulus(1, 200, lr, gp);

    $display("[TB] two back-to-back all-ones frames");
    add_frame(13'h1FFF);
    add_frame(13'h1FFF);
    applyStimulus(0, 200, lr, gp);
    checkOutput("b2b_ready_low", 8'(lr), 8'd4);
    checkOutput("b2b_no_gap", 8'(gp), 8'd0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) add_frame(13'($urandom));
    applyStimulus(2, 2000, lr, gp);

    $display("[TB] reset after 5 data bits");
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_bit = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("busy_mid", 8'(busy), 8'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 8'(out_valid), 8'd0);
    checkOutput("midrst_sof", 8'(sof), 8'd0);
    checkOutput("midrst_eof", 8'(eof), 8'd0);
    checkOutput("midrst_busy", 8'(busy), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m = 13'($urandom);
    m[0] = 1'b0;
    add_frame(m);
    applyStimulus(0, 100, lr, gp);

`ifdef CONV_ERR_INJECT_EN
    $display("[TB] error injection on first symbol");
    inject_next = 1'b1;
    add_frame(13'b0_0000_0000_1101);
    applyStimulus(0, 100, lr, gp);
    checkOutput("err_count", err_count, 8'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
